// File: rtl/gpio_pad_ctrl.sv
// Per-pin GPIO pad controller: registered push-pull/open-drain output drive,
// synchronised and debounced input with sticky edge-pending bits and one IRQ.
module gpio_pad_ctrl #(
  parameter int unsigned NPINS        = 8,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [NPINS-1:0] out_val_i,
  input  logic [NPINS-1:0] oe_i,
  input  logic [NPINS-1:0] od_i,
  output logic [NPINS-1:0] pad_i_o,
  output logic [NPINS-1:0] pad_t_o,
  input  logic [NPINS-1:0] pad_o_i,
  output logic [NPINS-1:0] in_val_o,
  input  logic [NPINS-1:0] rise_en_i,
  input  logic [NPINS-1:0] fall_en_i,
  input  logic [NPINS-1:0] irq_clr_i,
  output logic [NPINS-1:0] rise_pend_o,
  output logic [NPINS-1:0] fall_pend_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [NPINS-1:0] s1, s2, in_val;
  logic [NPINS-1:0] rise_pend, fall_pend;
  logic [NPINS-1:0] accept, rise_set, fall_set;
  logic [CNT_W-1:0] cnt     [NPINS];
  logic [CNT_W-1:0] cnt_nxt [NPINS];

  // Open-drain pins only ever drive low; a 1 releases the pad.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pad_i_o <= '0;
      pad_t_o <= '1;
    end else begin
      pad_i_o <= out_val_i & ~od_i;
      pad_t_o <= (od_i & out_val_i) | (~od_i & ~oe_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_o_i;
      s2 <= s1;
    end
  end

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < NPINS; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != in_val[i]) begin
        if (cnt[i] == CNT_LAST) accept[i] = 1'b1;
        else                    cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
    rise_set = accept &  s2 & rise_en_i;
    fall_set = accept & ~s2 & fall_en_i;
  end

  // A new edge on the same cycle as a clear keeps the pending bit set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_val    <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
      for (int unsigned i = 0; i < NPINS; i++) cnt[i] <= '0;
    end else begin
      in_val    <= in_val ^ accept;
      rise_pend <= rise_set | (rise_pend & ~irq_clr_i);
      fall_pend <= fall_set | (fall_pend & ~irq_clr_i);
      for (int unsigned i = 0; i < NPINS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign in_val_o    = in_val;
  assign rise_pend_o = rise_pend;
  assign fall_pend_o = fall_pend;
  assign irq_o       = |(rise_pend | fall_pend);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus random traffic, every cycle
// compared against a streak-counting behavioural model of the pin.
module tb_gpio_pad_ctrl;

  localparam int unsigned NP  = 8;
  localparam int unsigned DEB = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NP-1:0] out_val, oe, od, pad, rise_en, fall_en, irq_clr;
  logic [NP-1:0] pad_i_o, pad_t_o, in_val_o, rise_pend_o, fall_pend_o;
  logic          irq_o;

  int checks   = 0;
  int failures = 0;

  // Model state: pipeline samples, accepted level, run length of disagreeing samples.
  logic [NP-1:0] m_pi, m_pt, m_s1, m_s2, m_lvl, m_rise, m_fall;
  int            m_streak [NP];

  gpio_pad_ctrl #(.NPINS(NP), .DEBOUNCE_CYC(DEB), .CNT_W(8)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .out_val_i(out_val), .oe_i(oe), .od_i(od),
    .pad_i_o(pad_i_o), .pad_t_o(pad_t_o), .pad_o_i(pad),
    .in_val_o(in_val_o),
    .rise_en_i(rise_en), .fall_en_i(fall_en), .irq_clr_i(irq_clr),
    .rise_pend_o(rise_pend_o), .fall_pend_o(fall_pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pi = '0; m_pt = '1; m_s1 = '0; m_s2 = '0; m_lvl = '0;
    m_rise = '0; m_fall = '0;
    for (int p = 0; p < NP; p++) m_streak[p] = 0;
  endtask

  task automatic model_tick();
    for (int p = 0; p < NP; p++) begin
      m_pi[p] = od[p] ? 1'b0 : out_val[p];
      m_pt[p] = od[p] ? out_val[p] : ~oe[p];
    end
    m_rise = m_rise & ~irq_clr;
    m_fall = m_fall & ~irq_clr;
    for (int p = 0; p < NP; p++) begin
      if (m_s2[p] != m_lvl[p]) begin
        m_streak[p] = m_streak[p] + 1;
        if (m_streak[p] >= DEB) begin
          m_lvl[p]    = m_s2[p];
          m_streak[p] = 0;
          if (m_lvl[p]  && rise_en[p]) m_rise[p] = 1'b1;
          if (!m_lvl[p] && fall_en[p]) m_fall[p] = 1'b1;
        end
      end else begin
        m_streak[p] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = pad;
  endtask

  task automatic compare_all();
    check_val("pad_i",     32'(pad_i_o),     32'(m_pi));
    check_val("pad_t",     32'(pad_t_o),     32'(m_pt));
    check_val("in_val",    32'(in_val_o),    32'(m_lvl));
    check_val("rise_pend", 32'(rise_pend_o), 32'(m_rise));
    check_val("fall_pend", 32'(fall_pend_o), 32'(m_fall));
    check_val("irq",       32'(irq_o),       32'(|(m_rise | m_fall)));
  endtask

  // Inputs are changed only at the falling edge, right after this returns.
  task automatic step();
    @(posedge clk);
    if (rstn) model_tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rstn = 1'b0;
    out_val = NP'($urandom); oe = NP'($urandom); od = NP'($urandom);
    pad = NP'($urandom); rise_en = NP'($urandom); fall_en = NP'($urandom);
    irq_clr = NP'($urandom);
    model_reset();
    step(); step();
    check_val("rst_t",   32'(pad_t_o),  32'hFF);
    check_val("rst_i",   32'(pad_i_o),  32'h00);
    check_val("rst_in",  32'(in_val_o), 32'h00);
    check_val("rst_irq", 32'(irq_o),    32'h0);

    rstn = 1'b1;
    pad = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
    oe = 8'h0F; out_val = 8'h05; od = '0;
    step();
    check_val("pp_t", 32'(pad_t_o), 32'hF0);
    check_val("pp_i", 32'(pad_i_o), 32'h05);
    for (int i = 0; i < 4; i++) step();

    od = 8'h01; out_val = 8'h04;
    step();
    check_val("od0_i", 32'(pad_i_o[0]), 32'h0);
    check_val("od0_t", 32'(pad_t_o[0]), 32'h0);
    out_val = 8'h05;
    step();
    check_val("od1_t", 32'(pad_t_o[0]), 32'h1);
    oe[0] = ~oe[0];
    step();
    check_val("od_oe_t", 32'(pad_t_o[0]), 32'h1);
    check_val("od_oe_i", 32'(pad_i_o[0]), 32'h0);

    // Debounce latency: s1 captures at the first edge (k); in_val rises after edge k+5.
    pad[3] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      check_val("lat3", 32'(in_val_o[3]), (j >= 6) ? 32'h1 : 32'h0);
    end

    rise_en = '1;
    pad[2] = 1'b1;
    for (int j = 0; j < 3; j++) step();
    pad[2] = 1'b0;
    for (int j = 0; j < 8; j++) step();
    check_val("glitch_in",   32'(in_val_o[2]),    32'h0);
    check_val("glitch_rise", 32'(rise_pend_o[2]), 32'h0);
    check_val("glitch_irq",  32'(irq_o),          32'h0);

    rise_en = 8'h02; fall_en = '0;
    pad[1] = 1'b1;
    for (int j = 0; j < 8; j++) step();
    pad[1] = 1'b0;
    for (int j = 0; j < 8; j++) step();
    check_val("edge_rise", 32'(rise_pend_o[1]), 32'h1);
    check_val("edge_fall", 32'(fall_pend_o[1]), 32'h0);
    check_val("edge_irq",  32'(irq_o),          32'h1);
    irq_clr = 8'h02;
    step();
    irq_clr = '0;
    check_val("clr_rise", 32'(rise_pend_o[1]), 32'h0);
    check_val("clr_irq",  32'(irq_o),          32'h0);

    // Clear pulse lands exactly on the edge that accepts the new level.
    rise_en = 8'h20;
    pad[5] = 1'b1;
    for (int j = 0; j < 5; j++) step();
    irq_clr = 8'h20;
    step();
    irq_clr = '0;
    check_val("coll_rise", 32'(rise_pend_o[5]), 32'h1);
    check_val("coll_in",   32'(in_val_o[5]),    32'h1);

    pad[4] = 1'b1;
    for (int j = 0; j < 3; j++) step();
    #2 rstn = 1'b0;
    model_reset();
    step();
    check_val("mrst_in",  32'(in_val_o), 32'h00);
    check_val("mrst_irq", 32'(irq_o),    32'h0);
    rstn = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      step();
      check_val("mrst_lat4", 32'(in_val_o[4]), (j >= 6) ? 32'h1 : 32'h0);
    end

    for (int c = 0; c < 3000; c++) begin
      out_val = NP'($urandom); oe = NP'($urandom); od = NP'($urandom);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 7) == 0) pad[p] = ~pad[p];
      if ($urandom_range(0, 31) == 0) rise_en = NP'($urandom);
      if ($urandom_range(0, 31) == 0) fall_en = NP'($urandom);
      irq_clr = '0;
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 15) == 0) irq_clr[p] = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        #2 rstn = 1'b0;
        model_reset();
        step();
        rstn = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
